// File: rtl/functional_unit_prog.sv
// Programmable-table test FSM: rule registers define the state graph,
// the highest-index matching rule selects the next state.
module functional_unit_prog #(
  parameter int SW          = 4,
  parameter int XW          = 4,
  parameter int NRULES      = 32,
  parameter int IDXW        = 5,
  parameter int RESET_STATE = 0
) (
  input  logic                   clk,
  input  logic                   TLR,
  input  logic                   en,
  input  logic                   restart,
  input  logic [XW-1:0]          X,
  input  logic                   cfg_we,
  input  logic [IDXW-1:0]        cfg_addr,
  input  logic [2*SW+2*XW:0]     cfg_wdata,
  output logic [SW-1:0]          Yin,
  output logic                   hit,
  output logic [IDXW-1:0]        hit_idx,
  output logic [15:0]            trans_cnt
);

  localparam int RW = 1 + 2*SW + 2*XW;
  localparam logic [SW-1:0] RST_Y = SW'(RESET_STATE);

  logic [RW-1:0]   rule_q [NRULES];
  logic [SW-1:0]   y_q, y_d;
  logic            hit_q, hit_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            any_m;
  logic [IDXW-1:0] win_idx;
  logic [SW-1:0]   win_dst;

  // ascending scan: a later match overrides, so the top index wins
  always_comb begin
    any_m   = 1'b0;
    win_idx = '0;
    win_dst = '0;
    for (int i = 0; i < NRULES; i++) begin
      logic          v;
      logic [SW-1:0] src;
      logic [XW-1:0] msk, mat;
      v   = rule_q[i][RW-1];
      src = rule_q[i][RW-2 -: SW];
      msk = rule_q[i][SW+2*XW-1 -: XW];
      mat = rule_q[i][SW+XW-1 -: XW];
      if (v && src == y_q && (X & msk) == (mat & msk)) begin
        any_m   = 1'b1;
        win_idx = IDXW'(i);
        win_dst = rule_q[i][SW-1:0];
      end
    end
  end

  always_comb begin
    y_d   = y_q;
    hit_d = 1'b0;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (restart) begin
      y_d   = RST_Y;
      idx_d = '0;
      cnt_d = '0;
    end else if (en && any_m) begin
      y_d   = win_dst;
      hit_d = 1'b1;
      idx_d = win_idx;
      if (cnt_q != 16'hFFFF)
        cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge TLR) begin
    if (TLR) begin
      y_q   <= RST_Y;
      hit_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      hit_q <= hit_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge TLR) begin
    if (TLR) begin
      for (int i = 0; i < NRULES; i++)
        rule_q[i] <= '0;
    end else if (cfg_we && 32'(cfg_addr) < NRULES) begin
      rule_q[cfg_addr] <= cfg_wdata;
    end
  end

  assign Yin       = y_q;
  assign hit       = hit_q;
  assign hit_idx   = idx_q;
  assign trans_cnt = cnt_q;

endmodule

// File: tb/tb_functional_unit_prog.sv
// Scoreboard bench for functional_unit_prog: driver pushes expected
// results from a rule-list model, a monitor pops and compares.
module tb_functional_unit_prog;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        TLR;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic [3:0]  X = '0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [16:0] cfg_wdata = '0;
  logic [3:0]  Yin;
  logic        hit;
  logic [4:0]  hit_idx;
  logic [15:0] trans_cnt;

  functional_unit_prog dut (
    .clk(clk), .TLR(TLR), .en(en), .restart(restart), .X(X),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .Yin(Yin), .hit(hit), .hit_idx(hit_idx), .trans_cnt(trans_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  y;
    logic        h;
    logic [4:0]  idx;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model: a plain list of rules
  bit       r_v  [NR];
  bit [3:0] r_src[NR];
  bit [3:0] r_msk[NR];
  bit [3:0] r_mat[NR];
  bit [3:0] r_dst[NR];
  bit [3:0]  m_y;
  bit        m_hit;
  bit [4:0]  m_idx;
  int        m_cnt;

  function automatic logic [16:0] mk(input bit v, input bit [3:0] s,
    input bit [3:0] mk_, input bit [3:0] mt, input bit [3:0] d);
    return {v, s, mk_, mt, d};
  endfunction

  function automatic int winner(input bit [3:0] y, input bit [3:0] x);
    for (int i = NR - 1; i >= 0; i--)
      if (r_v[i] && r_src[i] == y && ((x ^ r_mat[i]) & r_msk[i]) == 0)
        return i;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      r_v[i] = 0; r_src[i] = 0; r_msk[i] = 0; r_mat[i] = 0; r_dst[i] = 0;
    end
    m_y = 0; m_hit = 0; m_idx = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input bit e, input bit r,
    input bit [3:0] x, input bit we, input bit [4:0] a, input bit [16:0] wd);
    int w;
    w = winner(m_y, x);
    if (r) begin
      m_y = 0; m_hit = 0; m_idx = 0; m_cnt = 0;
    end else if (e && w >= 0) begin
      m_y = r_dst[w]; m_hit = 1; m_idx = 5'(w);
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_hit = 0;
    end
    if (we && int'(a) < NR) begin
      r_v[a] = wd[16]; r_src[a] = wd[15:12]; r_msk[a] = wd[11:8];
      r_mat[a] = wd[7:4]; r_dst[a] = wd[3:0];
    end
  endfunction

  function automatic void push(input string nm);
    exp_t e;
    e.y = m_y; e.h = m_hit; e.idx = m_idx; e.cnt = 16'(m_cnt); e.nm = nm;
    q.push_back(e);
  endfunction

  task automatic step(input bit e, input bit r, input bit [3:0] x,
    input bit we, input bit [4:0] a, input bit [16:0] wd,
    input bit chk, input string nm);
    @(negedge clk);
    en = e; restart = r; X = x; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    @(posedge clk);
    model_edge(e, r, x, we, a, wd);
    if (chk) push(nm);
  endtask

  task automatic wr(input bit [4:0] a, input bit [16:0] wd);
    step(0, 0, 0, 1, a, wd, 0, "");
  endtask

  task automatic go(input bit [3:0] x, input bit chk, input string nm);
    step(1, 0, x, 0, 0, 0, chk, nm);
  endtask

  task automatic rst_step();
    step(1, 1, 0, 0, 0, 0, 0, "");
  endtask

  task automatic tlr_pulse(input string nm);
    @(negedge clk);
    en = 0; restart = 0; X = 0; cfg_we = 0;
    #2 TLR = 1'b1;
    model_reset();
    push(nm);
    #1 TLR = 1'b0;
    @(posedge clk);
    model_edge(0, 0, 0, 0, 0, 0);
  endtask

  // monitor: compares after each edge or async reset
  initial begin
    forever begin
      @(posedge clk or posedge TLR);
      #1;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (Yin !== e.y || hit !== e.h || hit_idx !== e.idx ||
            trans_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL %s: got Yin=%h hit=%b idx=%0d cnt=%h, want Yin=%h hit=%b idx=%0d cnt=%h",
            e.nm, Yin, hit, hit_idx, trans_cnt, e.y, e.h, e.idx, e.cnt);
        end
      end
    end
  end

  initial begin
    TLR = 1'b1;
    model_reset();
    @(posedge clk);
    push("reset");
    @(negedge clk);
    TLR = 1'b0;

    // T1: move off reset, then async TLR between edges
    wr(0, mk(1, 0, 4'hF, 4'h2, 4'h1));
    go(4'h2, 1, "t1_pre");
    tlr_pulse("t1_async");
    for (int i = 0; i < 4; i++)
      go(4'($urandom_range(0, 15)), 1, "t1_empty");

    // T2
    wr(0, mk(1, 0, 4'hF, 4'h2, 4'h1));
    go(4'h2, 1, "t2_move");
    go(4'h3, 1, "t2_nomove");

    // T3
    wr(3, mk(1, 1, 4'h0, 4'h0, 4'h5));
    wr(7, mk(1, 1, 4'hC, 4'h4, 4'hB));
    go(4'h6, 1, "t3_prio");
    rst_step();
    go(4'h2, 0, "");
    go(4'h0, 1, "t3_wild");

    // T4
    rst_step();
    go(4'h2, 0, "");
    step(1, 0, 4'h4, 1, 7, mk(1, 1, 4'hC, 4'h4, 4'hE), 1, "t4_old");
    rst_step();
    go(4'h2, 0, "");
    go(4'h4, 1, "t4_new");

    // T5
    rst_step();
    go(4'h2, 0, "");
    step(0, 0, 4'h4, 0, 0, 0, 1, "t5_en0");
    step(1, 1, 4'h4, 0, 0, 0, 1, "t5_restart");
    go(4'h2, 1, "t5_table");

    // T6: self-loop saturates the counter
    wr(31, mk(1, 0, 4'h0, 4'h0, 4'h0));
    rst_step();
    for (int i = 0; i < 70000; i++)
      go(4'($urandom_range(0, 15)), (i % 8192 == 0) || (i >= 69990),
         "t6_sat");

    // random table, steps, restarts
    tlr_pulse("rnd_tlr");
    for (int i = 0; i < 2000; i++) begin
      bit        e, r, we;
      bit [16:0] wd;
      e  = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 2) == 0);
      wd = mk(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)));
      step(e, r, 4'($urandom), we, 5'($urandom), wd, 1, "rnd");
    end

    @(negedge clk);
    en = 0; restart = 0; cfg_we = 0;
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
